// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: decoder control word layout and common constants.
package mips_pkg;

  // Field order matches the main decoder's 13-bit control word, MSB first.
  typedef struct packed {
    logic       Bne;
    logic       ExtOp;
    logic       RegWrite;
    logic       RegDst;
    logic       AluSrc;
    logic       Branch;
    logic       MemWrite;
    logic       MemToReg;
    logic       Jump;
    logic [2:0] AluOp;
    logic       DEn;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID/EX boundary bundle: decode-stage inputs, EX-stage outputs, hazard and stall signals.
interface id_ex_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int CNTW    = 16
);
  logic               StallE, FlushE;
  logic               RegWriteD, MemToRegD, MemWriteD, BranchD, BneD, AluSrcD, RegDstD, JumpD, DEnD;
  logic [2:0]         AluOpD;
  logic [REGBITS-1:0] RsD, RtD, RdD;
  logic [WIDTH-1:0]   RD1D, RD2D, SignImmD, PcPlus4D;

  logic               RegWriteE, MemToRegE, MemWriteE, BranchE, BneE, AluSrcE, RegDstE, JumpE, DEnE;
  logic [2:0]         AluOpE;
  logic [REGBITS-1:0] RsE, RtE, RdE;
  logic [WIDTH-1:0]   RD1E, RD2E, SignImmE, PcPlus4E;
  logic               ValidE, StallF, StallD;
  logic [CNTW-1:0]    BubbleCount;

  modport master (
    output StallE, FlushE,
    output RegWriteD, MemToRegD, MemWriteD, BranchD, BneD, AluSrcD, RegDstD, JumpD, DEnD,
    output AluOpD, RsD, RtD, RdD, RD1D, RD2D, SignImmD, PcPlus4D,
    input  RegWriteE, MemToRegE, MemWriteE, BranchE, BneE, AluSrcE, RegDstE, JumpE, DEnE,
    input  AluOpE, RsE, RtE, RdE, RD1E, RD2E, SignImmE, PcPlus4E,
    input  ValidE, StallF, StallD, BubbleCount
  );

  modport slave (
    input  StallE, FlushE,
    input  RegWriteD, MemToRegD, MemWriteD, BranchD, BneD, AluSrcD, RegDstD, JumpD, DEnD,
    input  AluOpD, RsD, RtD, RdD, RD1D, RD2D, SignImmD, PcPlus4D,
    output RegWriteE, MemToRegE, MemWriteE, BranchE, BneE, AluSrcE, RegDstE, JumpE, DEnE,
    output AluOpE, RsE, RtE, RdE, RD1E, RD2E, SignImmE, PcPlus4E,
    output ValidE, StallF, StallD, BubbleCount
  );
endinterface

// File: rtl/id_ex_pipe_hazard_loaduse.sv
// Combinational load-use detector: a valid load in EX whose target feeds the instruction in ID.
module hazard_loaduse
  import mips_pkg::*;
#(
  parameter int REGBITS = 5
) (
  input  logic               MemToRegE,
  input  logic               RegWriteE,
  input  logic               ValidE,
  input  logic               StallE,
  input  logic [REGBITS-1:0] RtE,
  input  logic [REGBITS-1:0] RsD,
  input  logic [REGBITS-1:0] RtD,
  output logic               LoadUse,
  output logic               StallF,
  output logic               StallD
);

  // Loads into $0 are discarded by the register file, so they never need a stall.
  always_comb begin
    LoadUse = MemToRegE & RegWriteE & ValidE & (RtE != REGBITS'(REG_ZERO)) &
              ((RtE == RsD) | (RtE == RtD));
    StallF  = LoadUse & ~StallE;
    StallD  = LoadUse & ~StallE;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall generation, flush bubbles and a saturating bubble counter.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int CNTW    = 16
) (
  input  logic clk,
  input  logic reset,
  id_ex_if.slave bus
);

  ctrl_t              ctrl_d, ctrl_e;
  logic [REGBITS-1:0] rs_e, rt_e, rd_e;
  logic [WIDTH-1:0]   rd1_e, rd2_e, simm_e, pc4_e;
  logic               valid_e;
  logic [CNTW-1:0]    bubble_cnt;
  logic               load_use;

  always_comb begin
    ctrl_d          = CTRL_NOP;
    ctrl_d.Bne      = bus.BneD;
    ctrl_d.RegWrite = bus.RegWriteD;
    ctrl_d.RegDst   = bus.RegDstD;
    ctrl_d.AluSrc   = bus.AluSrcD;
    ctrl_d.Branch   = bus.BranchD;
    ctrl_d.MemWrite = bus.MemWriteD;
    ctrl_d.MemToReg = bus.MemToRegD;
    ctrl_d.Jump     = bus.JumpD;
    ctrl_d.AluOp    = bus.AluOpD;
    ctrl_d.DEn      = bus.DEnD;
  end

  hazard_loaduse #(.REGBITS(REGBITS)) u_hazard (
    .MemToRegE (ctrl_e.MemToReg),
    .RegWriteE (ctrl_e.RegWrite),
    .ValidE    (valid_e),
    .StallE    (bus.StallE),
    .RtE       (rt_e),
    .RsD       (bus.RsD),
    .RtD       (bus.RtD),
    .LoadUse   (load_use),
    .StallF    (bus.StallF),
    .StallD    (bus.StallD)
  );

  // Bubbles clear specifiers too, so a stale RtE can never raise a false hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e     <= CTRL_NOP;
      {rs_e, rt_e, rd_e}             <= '0;
      {rd1_e, rd2_e, simm_e, pc4_e}  <= '0;
      valid_e    <= 1'b0;
      bubble_cnt <= '0;
    end else if (!bus.StallE) begin
      if (bus.FlushE || load_use) begin
        ctrl_e  <= CTRL_NOP;
        {rs_e, rt_e, rd_e}            <= '0;
        {rd1_e, rd2_e, simm_e, pc4_e} <= '0;
        valid_e <= 1'b0;
        if (bubble_cnt != {CNTW{1'b1}})
          bubble_cnt <= bubble_cnt + CNTW'(1);
      end else begin
        ctrl_e  <= ctrl_d;
        rs_e    <= bus.RsD;
        rt_e    <= bus.RtD;
        rd_e    <= bus.RdD;
        rd1_e   <= bus.RD1D;
        rd2_e   <= bus.RD2D;
        simm_e  <= bus.SignImmD;
        pc4_e   <= bus.PcPlus4D;
        valid_e <= 1'b1;
      end
    end
  end

  assign bus.RegWriteE   = ctrl_e.RegWrite;
  assign bus.MemToRegE   = ctrl_e.MemToReg;
  assign bus.MemWriteE   = ctrl_e.MemWrite;
  assign bus.BranchE     = ctrl_e.Branch;
  assign bus.BneE        = ctrl_e.Bne;
  assign bus.AluSrcE     = ctrl_e.AluSrc;
  assign bus.RegDstE     = ctrl_e.RegDst;
  assign bus.JumpE       = ctrl_e.Jump;
  assign bus.DEnE        = ctrl_e.DEn;
  assign bus.AluOpE      = ctrl_e.AluOp;
  assign bus.RsE         = rs_e;
  assign bus.RtE         = rt_e;
  assign bus.RdE         = rd_e;
  assign bus.RD1E        = rd1_e;
  assign bus.RD2E        = rd2_e;
  assign bus.SignImmE    = simm_e;
  assign bus.PcPlus4E    = pc4_e;
  assign bus.ValidE      = valid_e;
  assign bus.BubbleCount = bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: reference model pushes expected E-stage snapshots to a queue.
module tb_id_ex_pipe;

  typedef struct packed {
    logic        regwrite, memtoreg, memwrite, branch, bne, alusrc, regdst, jump, den;
    logic [2:0]  aluop;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, simm, pc4;
    logic        valid;
    logic [3:0]  bc;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_if #(.WIDTH(32), .REGBITS(5), .CNTW(4)) bus ();
  id_ex_pipe #(.WIDTH(32), .REGBITS(5), .CNTW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  snap_t mdl = '0;
  snap_t cur_d = '0;
  logic  m_stalle = 1'b0, m_flushe = 1'b0;
  snap_t exp_q[$];
  int    checks = 0, passes = 0;

  function automatic snap_t sample();
    snap_t s;
    s = '0;
    s.regwrite = bus.RegWriteE; s.memtoreg = bus.MemToRegE; s.memwrite = bus.MemWriteE;
    s.branch = bus.BranchE; s.bne = bus.BneE; s.alusrc = bus.AluSrcE; s.regdst = bus.RegDstE;
    s.jump = bus.JumpE; s.den = bus.DEnE; s.aluop = bus.AluOpE;
    s.rs = bus.RsE; s.rt = bus.RtE; s.rd = bus.RdE;
    s.rd1 = bus.RD1E; s.rd2 = bus.RD2E; s.simm = bus.SignImmE; s.pc4 = bus.PcPlus4E;
    s.valid = bus.ValidE; s.bc = bus.BubbleCount;
    return s;
  endfunction

  function automatic logic model_lu(snap_t e, snap_t d);
    return e.memtoreg & e.regwrite & e.valid & (e.rt != 5'd0) & ((e.rt == d.rs) | (e.rt == d.rt));
  endfunction

  task automatic drive(input snap_t d, input logic st, input logic fl, input logic rs);
    cur_d = d; m_stalle = st; m_flushe = fl; reset = rs;
    bus.StallE = st; bus.FlushE = fl;
    bus.RegWriteD = d.regwrite; bus.MemToRegD = d.memtoreg; bus.MemWriteD = d.memwrite;
    bus.BranchD = d.branch; bus.BneD = d.bne; bus.AluSrcD = d.alusrc; bus.RegDstD = d.regdst;
    bus.JumpD = d.jump; bus.DEnD = d.den; bus.AluOpD = d.aluop;
    bus.RsD = d.rs; bus.RtD = d.rt; bus.RdD = d.rd;
    bus.RD1D = d.rd1; bus.RD2D = d.rd2; bus.SignImmD = d.simm; bus.PcPlus4D = d.pc4;
    #1;
  endtask

  // Predict the next E-stage state, queue it, and advance one clock.
  task automatic tick();
    snap_t n;
    if (reset) n = '0;
    else if (m_stalle) n = mdl;
    else if (m_flushe || model_lu(mdl, cur_d)) begin
      n = '0;
      n.bc = (mdl.bc == 4'hF) ? 4'hF : mdl.bc + 4'd1;
    end else begin
      n = cur_d;
      n.valid = 1'b1;
      n.bc = mdl.bc;
    end
    exp_q.push_back(n);
    mdl = n;
    @(posedge clk);
    #1;
  endtask

  function automatic snap_t rand_d();
    snap_t d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d.rs = 5'($urandom_range(0, 3));
    d.rt = 5'($urandom_range(0, 3));
    d.valid = 1'b0;
    d.bc = 4'd0;
    return d;
  endfunction

  task automatic test_reset();
    snap_t d, e, o;
    d = rand_d();
    d.memtoreg = 1'b1; d.regwrite = 1'b1;
    drive(d, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) $display("FAIL reset_state: got %h expected %h", o, e); else passes++;
    end
    checks++;
    if (o !== '0) $display("FAIL reset_zero: got %h expected 0", o); else passes++;
    checks++;
    if ({bus.StallF, bus.StallD} !== 2'b00)
      $display("FAIL reset_stall: got %b expected 00", {bus.StallF, bus.StallD});
    else passes++;
  endtask

  task automatic test_normal();
    snap_t d, e, o;
    d = '0;
    d.regwrite = 1'b1; d.regdst = 1'b1; d.aluop = 3'b011;
    d.rs = 5'd1; d.rt = 5'd2; d.rd = 5'd3; d.rd1 = 32'h5; d.rd2 = 32'h7; d.pc4 = 32'h104;
    drive(d, 1'b0, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) $display("FAIL normal_add: got %h expected %h", o, e); else passes++;
    checks++;
    if ({o.regwrite, o.valid, o.rd1, o.rd2} !== {1'b1, 1'b1, 32'h5, 32'h7})
      $display("FAIL normal_fields: got %h expected %h", {o.regwrite, o.valid, o.rd1, o.rd2},
               {1'b1, 1'b1, 32'h5, 32'h7});
    else passes++;
  endtask

  task automatic test_load_use();
    snap_t lw, use_i, e, o;
    logic [3:0] bc0;
    lw = '0;
    lw.regwrite = 1'b1; lw.memtoreg = 1'b1; lw.alusrc = 1'b1; lw.rs = 5'd29; lw.rt = 5'd8; lw.simm = 32'h10;
    use_i = '0;
    use_i.regwrite = 1'b1; use_i.regdst = 1'b1; use_i.rs = 5'd8; use_i.rt = 5'd9; use_i.rd = 5'd10;
    use_i.rd1 = 32'hAAAA; use_i.rd2 = 32'hBBBB;
    drive(lw, 1'b0, 1'b0, 1'b0);
    tick();
    void'(exp_q.pop_front());
    bc0 = bus.BubbleCount;
    drive(use_i, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.StallF, bus.StallD} !== 2'b11)
      $display("FAIL loaduse_stall: got %b expected 11", {bus.StallF, bus.StallD});
    else passes++;
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) $display("FAIL loaduse_bubble: got %h expected %h", o, e); else passes++;
    checks++;
    if ({o.valid, o.bc} !== {1'b0, bc0 + 4'd1})
      $display("FAIL loaduse_count: got %h expected %h", {o.valid, o.bc}, {1'b0, bc0 + 4'd1});
    else passes++;
    checks++;
    if (bus.StallD !== 1'b0) $display("FAIL loaduse_release: got %b expected 0", bus.StallD); else passes++;
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e || o.rs !== 5'd8 || o.valid !== 1'b1)
      $display("FAIL loaduse_capture: got %h expected %h", o, e);
    else passes++;
  endtask

  task automatic test_zero_reg();
    snap_t lw, d, e, o;
    logic [3:0] bc0;
    lw = '0;
    lw.regwrite = 1'b1; lw.memtoreg = 1'b1; lw.rt = 5'd0; lw.rs = 5'd4;
    d = '0;
    d.regwrite = 1'b1; d.rs = 5'd0; d.rt = 5'd0; d.rd = 5'd5; d.rd1 = 32'h1234;
    drive(lw, 1'b0, 1'b0, 1'b0);
    tick();
    void'(exp_q.pop_front());
    bc0 = bus.BubbleCount;
    drive(d, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.StallD !== 1'b0) $display("FAIL zero_stall: got %b expected 0", bus.StallD); else passes++;
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e || o.valid !== 1'b1 || o.bc !== bc0)
      $display("FAIL zero_no_bubble: got %h expected %h", o, e);
    else passes++;
  endtask

  task automatic test_flush_and_load_use();
    snap_t lw, d, e, o;
    logic [3:0] bc0;
    lw = '0;
    lw.regwrite = 1'b1; lw.memtoreg = 1'b1; lw.rt = 5'd12;
    d = '0;
    d.rt = 5'd12; d.memwrite = 1'b1;
    drive(lw, 1'b0, 1'b0, 1'b0);
    tick();
    void'(exp_q.pop_front());
    bc0 = bus.BubbleCount;
    drive(d, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.StallD !== 1'b1) $display("FAIL flush_lu_stall: got %b expected 1", bus.StallD); else passes++;
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e || o.bc !== bc0 + 4'd1)
      $display("FAIL flush_lu_once: got %h expected %h", o, e);
    else passes++;
  endtask

  task automatic test_stall_hold();
    snap_t d, held, e, o;
    d = rand_d();
    d.memtoreg = 1'b0;
    drive(d, 1'b0, 1'b0, 1'b0);
    tick();
    void'(exp_q.pop_front());
    held = sample();
    drive(rand_d(), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e || o !== held) $display("FAIL stalle_hold: got %h expected %h", o, e); else passes++;
    end
    drive(cur_d, 1'b0, 1'b1, 1'b0);
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e || o.valid !== 1'b0) $display("FAIL stalle_release: got %h expected %h", o, e); else passes++;
  endtask

  task automatic test_back_to_back();
    snap_t d, e, o;
    logic st, fl, exp_st;
    for (int i = 0; i < 60; i++) begin
      d = rand_d();
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 5) == 0);
      drive(d, st, fl, 1'b0);
      exp_st = model_lu(mdl, cur_d) & ~st;
      checks++;
      if ({bus.StallF, bus.StallD} !== {2{exp_st}})
        $display("FAIL b2b_stall: got %b expected %b", {bus.StallF, bus.StallD}, {2{exp_st}});
      else passes++;
      tick();
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) $display("FAIL b2b_state: got %h expected %h", o, e); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    drive(rand_d(), 1'b0, 1'b0, 1'b1);
    tick();
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e || o !== '0) $display("FAIL reset_mid: got %h expected %h", o, e); else passes++;
  endtask

  task automatic test_saturate();
    snap_t e, o;
    drive(rand_d(), 1'b0, 1'b0, 1'b1);
    tick();
    void'(exp_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(rand_d(), 1'b0, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) $display("FAIL saturate_step: got %h expected %h", o, e); else passes++;
    end
    checks++;
    if (bus.BubbleCount !== 4'hF) $display("FAIL saturate_final: got %h expected f", bus.BubbleCount); else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_zero_reg();
    test_flush_and_load_use();
    test_stall_hold();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
